// File: rtl/lcd_msg_sequencer.sv
// Streams one status text line from an external char table to the HD44780 byte writer.
// Optional clear-before-write, otherwise the line is space-padded for flicker-free refresh.
module lcd_msg_sequencer #(
    parameter int         MODE_W    = 3,
    parameter int         LINE_LEN  = 16,
    parameter logic [7:0] LINE_ADDR = 8'h00,
    parameter bit         CLEAR_EN  = 1'b0,
    localparam int        POS_W     = $clog2(LINE_LEN + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_init_done,
    input  logic              i_start,
    input  logic [MODE_W-1:0] i_mode,
    output logic [MODE_W-1:0] o_char_mode,
    output logic [POS_W-1:0]  o_char_pos,
    input  logic [7:0]        i_char,
    output logic              o_cmd_valid,
    output logic              o_cmd_rs,
    output logic [7:0]        o_cmd_data,
    input  logic              i_cmd_done,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ADDR,
        S_FETCH,
        S_CHAR,
        S_PAD,
        S_FIN
    } state_t;

    state_t              state_reg, state_next;
    logic [MODE_W-1:0]   mode_reg, mode_next;
    logic [MODE_W-1:0]   pend_mode_reg, pend_mode_next;
    logic                pend_reg, pend_next;
    logic [POS_W-1:0]    pos_reg, pos_next;
    logic [7:0]          char_reg, char_next;
    logic                valid_reg, valid_next;
    logic                rs_reg, rs_next;
    logic [7:0]          data_reg, data_next;

    logic                issue;
    logic                issue_rs;
    logic [7:0]          issue_data;
    logic                byte_done;
    logic                last_pos;
    state_t              first_state;

    assign byte_done   = valid_reg && i_cmd_done;
    assign last_pos    = (pos_reg == POS_W'(LINE_LEN - 1));
    assign first_state = CLEAR_EN ? S_CLEAR : S_ADDR;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= S_IDLE;
            mode_reg      <= '0;
            pend_mode_reg <= '0;
            pend_reg      <= 1'b0;
            pos_reg       <= '0;
            char_reg      <= '0;
            valid_reg     <= 1'b0;
            rs_reg        <= 1'b0;
            data_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            pend_mode_reg <= pend_mode_next;
            pend_reg      <= pend_next;
            pos_reg       <= pos_next;
            char_reg      <= char_next;
            valid_reg     <= valid_next;
            rs_reg        <= rs_next;
            data_reg      <= data_next;
        end
    end

    always_comb begin
        issue      = 1'b0;
        issue_rs   = 1'b0;
        issue_data = 8'h00;
        case (state_reg)
            S_CLEAR: begin issue = 1'b1; issue_rs = 1'b0; issue_data = 8'h01; end
            S_ADDR:  begin issue = 1'b1; issue_rs = 1'b0; issue_data = 8'h80 | LINE_ADDR; end
            S_CHAR:  begin issue = 1'b1; issue_rs = 1'b1; issue_data = char_reg; end
            S_PAD:   begin issue = 1'b1; issue_rs = 1'b1; issue_data = 8'h20; end
            default: ;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        pend_mode_next = pend_mode_reg;
        pend_next      = pend_reg;
        pos_next       = pos_reg;
        char_next      = char_reg;
        valid_next     = valid_reg;
        rs_next        = rs_reg;
        data_next      = data_reg;

        // rs/data are captured only when valid rises, so they cannot move mid-handshake
        if (byte_done) begin
            valid_next = 1'b0;
        end else if (issue && !valid_reg) begin
            valid_next = 1'b1;
            rs_next    = issue_rs;
            data_next  = issue_data;
        end

        case (state_reg)
            S_IDLE: begin
                if (i_start && i_init_done) begin
                    state_next = first_state;
                    mode_next  = i_mode;
                    pos_next   = '0;
                end
            end
            S_CLEAR: if (byte_done) state_next = S_ADDR;
            S_ADDR:  if (byte_done) state_next = S_FETCH;
            S_FETCH: begin
                char_next = i_char;
                if (i_char != 8'h00) state_next = S_CHAR;
                else                 state_next = CLEAR_EN ? S_FIN : S_PAD;
            end
            S_CHAR, S_PAD: begin
                if (byte_done) begin
                    if (last_pos) begin
                        state_next = S_FIN;
                    end else begin
                        pos_next   = pos_reg + POS_W'(1);
                        state_next = (state_reg == S_CHAR) ? S_FETCH : S_PAD;
                    end
                end
            end
            S_FIN: begin
                // A request arriving this very cycle is the newest one and wins over the queued mode
                pend_next = 1'b0;
                if (pend_reg || i_start) begin
                    state_next = first_state;
                    mode_next  = i_start ? i_mode : pend_mode_reg;
                    pos_next   = '0;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (i_start && state_reg != S_IDLE && state_reg != S_FIN) begin
            pend_next      = 1'b1;
            pend_mode_next = i_mode;
        end
    end

    assign o_char_mode = mode_reg;
    assign o_char_pos  = pos_reg;
    assign o_cmd_valid = valid_reg;
    assign o_cmd_rs    = rs_reg;
    assign o_cmd_data  = data_reg;
    assign o_busy      = (state_reg != S_IDLE);
    assign o_done      = (state_reg == S_FIN);

endmodule
